// File: rtl/dma_arbiter_if.sv
// rtl/dma_arbiter_if.sv - requester and DMA signal bundle for dma_arbiter
interface dma_arbiter_if #(
  parameter int MEM_ADDRESS_WIDTH = 10,
  parameter int LAYER_SZ          = 7
);
  logic [1:0]                     req;
  logic [2*MEM_ADDRESS_WIDTH-1:0] req_address;
  logic [2*LAYER_SZ-1:0]          req_count;
  logic [1:0]                     ready;
  logic [1:0]                     timeout;
  logic [1:0]                     overflow;
  logic                           DMA_read;
  logic [MEM_ADDRESS_WIDTH-1:0]   DMA_address;
  logic [LAYER_SZ-1:0]            DMA_count;
  logic                           DMA_ready;
  logic                           owner;
  logic                           busy;

  // Arbiter side
  modport slave (
    input  req, req_address, req_count, DMA_ready,
    output ready, timeout, overflow, DMA_read, DMA_address, DMA_count, owner, busy
  );

  // Requester / DMA side
  modport master (
    output req, req_address, req_count, DMA_ready,
    input  ready, timeout, overflow, DMA_read, DMA_address, DMA_count, owner, busy
  );
endinterface

// File: rtl/dma_arbiter.sv
// rtl/dma_arbiter.sv - two-port round-robin burst arbiter for the DMA read port
module dma_arbiter #(
  parameter int MEM_ADDRESS_WIDTH = 10,
  parameter int LAYER_SZ          = 7,
  parameter int TIMEOUT           = 1023
) (
  input logic          clk,
  input logic          rst,
  input logic          clk_en,
  dma_arbiter_if.slave bus
);
  localparam int AW = MEM_ADDRESS_WIDTH;
  localparam int LS = LAYER_SZ;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [9:0] WD_MAX = 10'(TIMEOUT);

  logic [1:0]    state;
  logic [1:0]    pending;
  logic [1:0]    overflow_q;
  logic [AW-1:0] buf_addr [2];
  logic [LS-1:0] buf_cnt  [2];
  logic          last;
  logic          owner_q;
  logic          abort_q;
  logic [9:0]    wd_cnt;
  logic [AW-1:0] dma_addr_q;
  logic [LS-1:0] dma_cnt_q;

  logic       grant_en;
  logic       grant_port;
  logic [1:0] grant_clr;

  // Pick the port to grant from IDLE; on a tie the port that was not served last wins
  always_comb begin
    grant_en   = (state == S_IDLE) && (pending != 2'b00);
    grant_port = (pending == 2'b11) ? ~last : pending[1];
    grant_clr  = 2'b00;
    if (grant_en) begin
      grant_clr = grant_port ? 2'b10 : 2'b01;
    end
  end

  // Per-port request buffers; a request landing on the grant edge refills the slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= 2'b00;
      overflow_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        buf_addr[i] <= '0;
        buf_cnt[i]  <= '0;
      end
    end else if (clk_en) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.req[i] && (!pending[i] || grant_clr[i])) begin
          pending[i]  <= 1'b1;
          buf_addr[i] <= bus.req_address[i*AW +: AW];
          buf_cnt[i]  <= bus.req_count[i*LS +: LS];
        end else begin
          if (grant_clr[i]) pending[i] <= 1'b0;
          if (bus.req[i])   overflow_q[i] <= 1'b1;
        end
      end
    end
  end

  // Burst sequencer with watchdog; zero-length bursts skip the DMA entirely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last       <= 1'b1;
      owner_q    <= 1'b0;
      abort_q    <= 1'b0;
      wd_cnt     <= '0;
      dma_addr_q <= '0;
      dma_cnt_q  <= '0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (grant_en) begin
            owner_q    <= grant_port;
            dma_addr_q <= buf_addr[grant_port];
            dma_cnt_q  <= buf_cnt[grant_port];
            abort_q    <= 1'b0;
            state      <= (buf_cnt[grant_port] == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.DMA_ready) begin
            state <= S_DONE;
          end else if (wd_cnt == WD_MAX) begin
            abort_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 10'd1;
          end
        end
        default: begin
          last  <= owner_q;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore output decode from registered state
  always_comb begin
    bus.ready       = (state == S_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    bus.timeout     = (state == S_DONE && abort_q) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    bus.overflow    = overflow_q;
    bus.DMA_read    = (state == S_ISSUE);
    bus.DMA_address = dma_addr_q;
    bus.DMA_count   = dma_cnt_q;
    bus.owner       = owner_q;
    bus.busy        = (state != S_IDLE);
  end
endmodule
